// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Sequencing stage that sits directly in front of a combinational ALU.
// Holds a 2**REG_AW x DATA_W operand register file, accepts one operation
// at a time over a valid/ready handshake, presents registered operands and
// the opcode to the ALU, captures the ALU result and writes it back.
// Each operation walks IDLE -> EXEC -> WB, so one operation every 3 cycles.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_op/ra/rb/rd          opcode, source registers, destination register
//   ld_en/ld_addr/ld_data    side load port (writes in any state)
//   alu_a/alu_b/alu_op       registered operands and opcode to the ALU
//   alu_out                  combinational ALU result
//   done/done_err            completion pulse / illegal-opcode flag
//   done_rd/done_data        destination and result of completed op
//   dbg_addr/dbg_data        combinational debug read of the register file
//
// Optional feature: define ALU_ISSUE_R0_ZERO_EN to hard-wire register 0
// to zero (reads return 0, writes from WB or the load port are dropped).
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [REG_AW-1:0] req_ra,
  input  logic [REG_AW-1:0] req_rb,
  input  logic [REG_AW-1:0] req_rd,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              done,
  output logic              done_err,
  output logic [REG_AW-1:0] done_rd,
  output logic [DATA_W-1:0] done_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 1 << REG_AW;

  // Legal opcodes are the contiguous range ADD (0x01) .. NOR (0x06).
  localparam logic [OP_W-1:0] OP_FIRST = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LAST  = OP_W'(6);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] read_a, read_b, read_dbg;
  logic              op_legal;

  // Register-file read ports. With the zero-register option, address 0
  // reads as 0 regardless of storage contents.
  always_comb begin
    read_a   = rf_q[req_ra];
    read_b   = rf_q[req_rb];
    read_dbg = rf_q[dbg_addr];
`ifdef ALU_ISSUE_R0_ZERO_EN
    if (req_ra == '0)   read_a   = '0;
    if (req_rb == '0)   read_b   = '0;
    if (dbg_addr == '0) read_dbg = '0;
`endif
  end

  assign op_legal = (op_q >= OP_FIRST) && (op_q <= OP_LAST);

  // Next-state and register-file update. The WB write is applied after the
  // load-port write so that a same-address collision keeps the WB value.
  // Operands are taken from rf_q, so a load in the accept cycle is not seen.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    rd_d     = rd_q;
    result_d = result_q;
    err_d    = err_q;
    rf_d     = rf_q;

    if (ld_en) rf_d[ld_addr] = ld_data;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          a_d     = read_a;
          b_d     = read_b;
          op_d    = req_op;
          rd_d    = req_rd;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Result is captured even for an illegal opcode; only writeback is
        // suppressed.
        result_d = alu_out;
        err_d    = ~op_legal;
        state_d  = WB;
      end
      WB: begin
        if (!err_q) rf_d[rd_q] = result_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef ALU_ISSUE_R0_ZERO_EN
    rf_d[0] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      err_q    <= err_d;
      rf_q     <= rf_d;
    end
  end

  // Reset masks ready and done combinationally so an aborted operation
  // never signals completion on the reset cycle itself.
  assign req_ready = (state_q == IDLE) && !rst;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = (state_q == EXEC) ? op_q : '0;
  assign done      = (state_q == WB) && !rst;
  assign done_err  = done && err_q;
  assign done_rd   = rd_q;
  assign done_data = result_q;
  assign dbg_data  = read_dbg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Self-checking bench for alu_issue_ctrl. A behavioural ALU drives alu_out.
// A reference register-file model predicts each operation's result; the
// expected completion is queued when the request is driven and compared
// when the DUT pulses done. Honours ALU_ISSUE_R0_ZERO_EN when defined.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [2:0]  req_ra, req_rb, req_rd;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_out;
  logic        done, done_err;
  logic [2:0]  done_rd;
  logic [31:0] done_data;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  typedef struct {
    logic [2:0]  rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ref_rf [8];
  int          n_vec = 0;
  int          n_err = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .done(done), .done_err(done_err), .done_rd(done_rd), .done_data(done_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Behavioural ALU; unknown opcodes produce a recognisable pattern.
  function automatic logic [31:0] aluModel(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      5'h01:   return a + b;
      5'h02:   return a - b;
      5'h03:   return a & b;
      5'h04:   return a | b;
      5'h05:   return a ^ b;
      5'h06:   return ~(a | b);
      default: return a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  always_comb alu_out = aluModel(alu_op, alu_a, alu_b);

  function automatic logic writable(input logic [2:0] addr);
`ifdef ALU_ISSUE_R0_ZERO_EN
    return addr != 3'd0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] refRead(input logic [2:0] addr);
`ifdef ALU_ISSUE_R0_ZERO_EN
    if (addr == 3'd0) return 32'h0;
`endif
    return ref_rf[addr];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Queue the expected completion and update the reference register file.
  task automatic pushExpect(input logic [4:0] op, input logic [2:0] ra, input logic [2:0] rb,
                            input logic [2:0] rd);
    exp_t e;
    e.rd   = rd;
    e.data = aluModel(op, refRead(ra), refRead(rb));
    e.err  = !(op >= 5'h01 && op <= 5'h06);
    exp_q.push_back(e);
    if (!e.err && writable(rd)) ref_rf[rd] = e.data;
  endtask

  // Completion monitor: pops one expectation per done pulse.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() == 0) begin
      checkOutput("spurious_done", 32'(done), 32'h0);
    end else if (done) begin
      mon_e = exp_q.pop_front();
      checkOutput("done_rd", 32'(done_rd), 32'(mon_e.rd));
      checkOutput("done_data", done_data, mon_e.data);
      checkOutput("done_err", 32'(done_err), 32'(mon_e.err));
    end
  end

  task automatic checkDbg(input logic [2:0] addr);
    dbg_addr = addr;
    #1;
    checkOutput($sformatf("dbg_r%0d", addr), dbg_data, refRead(addr));
  endtask

  task automatic loadReg(input logic [2:0] addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    tick();
    ld_en = 1'b0;
    if (writable(addr)) ref_rf[addr] = data;
    checkDbg(addr);
  endtask

  // Issue one request (optionally with a same-cycle load) and step to WB.
  task automatic applyStimulus(input logic [4:0] op, input logic [2:0] ra, input logic [2:0] rb,
                               input logic [2:0] rd, input logic ld, input logic [2:0] la,
                               input logic [31:0] ldat);
    logic [31:0] exp_a, exp_b;
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    checkOutput("ready_wait", 32'(req_ready), 32'h1);
    exp_a     = refRead(ra);
    exp_b     = refRead(rb);
    req_valid = 1'b1;
    req_op    = op;
    req_ra    = ra;
    req_rb    = rb;
    req_rd    = rd;
    if (ld) begin
      ld_en   = 1'b1;
      ld_addr = la;
      ld_data = ldat;
    end
    pushExpect(op, ra, rb, rd);
    if (ld && writable(la)) ref_rf[la] = ldat;
    tick();
    req_valid = 1'b0;
    ld_en     = 1'b0;
    checkOutput("exec_alu_a", alu_a, exp_a);
    checkOutput("exec_alu_b", alu_b, exp_b);
    checkOutput("exec_alu_op", 32'(alu_op), 32'(op));
    checkOutput("exec_ready", 32'(req_ready), 32'h0);
    tick();
    checkOutput("wb_alu_op", 32'(alu_op), 32'h0);
    checkOutput("wb_ready", 32'(req_ready), 32'h0);
  endtask

  task automatic completeOp(input logic [2:0] rd);
    tick();
    checkOutput("idle_ready", 32'(req_ready), 32'h1);
    checkDbg(rd);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_ra = '0; req_rb = '0; req_rd = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 32'h0;

    tick();
    tick();
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(req_ready), 32'h1);
    checkOutput("post_rst_alu_a", alu_a, 32'h0);
    checkOutput("post_rst_alu_b", alu_b, 32'h0);
    checkOutput("post_rst_done_rd", 32'(done_rd), 32'h0);
    checkOutput("post_rst_done_data", done_data, 32'h0);
    tick();

    // Basic arithmetic and logic.
    loadReg(3'd1, 32'd5);
    loadReg(3'd2, 32'd3);
    applyStimulus(5'h01, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 32'h0);
    completeOp(3'd3);
    applyStimulus(5'h02, 3'd2, 3'd1, 3'd6, 1'b0, 3'd0, 32'h0);
    completeOp(3'd6);
    applyStimulus(5'h06, 3'd0, 3'd7, 3'd7, 1'b0, 3'd0, 32'h0);
    completeOp(3'd7);
    loadReg(3'd5, 32'hF0F0_A5A5);
    loadReg(3'd6, 32'h0FF0_3C3C);
    for (int op = 3; op <= 5; op++) begin
      applyStimulus(5'(op), 3'd5, 3'd6, 3'd7, 1'b0, 3'd0, 32'h0);
      completeOp(3'd7);
    end

    // Illegal opcode: flagged, no writeback to r3.
    applyStimulus(5'h07, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 32'h0);
    completeOp(3'd3);

    // Back-to-back requests with req_valid held high.
    req_valid = 1'b1; req_op = 5'h01; req_ra = 3'd3; req_rb = 3'd1; req_rd = 3'd4;
    pushExpect(5'h01, 3'd3, 3'd1, 3'd4);
    tick();
    req_ra = 3'd4;
    checkOutput("b2b_ready_n1", 32'(req_ready), 32'h0);
    tick();
    checkOutput("b2b_ready_n2", 32'(req_ready), 32'h0);
    tick();
    checkOutput("b2b_ready_n3", 32'(req_ready), 32'h1);
    pushExpect(5'h01, 3'd4, 3'd1, 3'd4);
    tick();
    req_valid = 1'b0;
    checkOutput("b2b_alu_a", alu_a, 32'd13);
    tick();
    completeOp(3'd4);
    checkOutput("b2b_r4", dbg_data, 32'd18);

    // Load and WB to the same address in one cycle: WB wins.
    applyStimulus(5'h01, 3'd1, 3'd1, 3'd7, 1'b0, 3'd0, 32'h0);
    ld_en = 1'b1; ld_addr = 3'd7; ld_data = 32'h55;
    completeOp(3'd7);
    ld_en = 1'b0;

    // Load in the accept cycle: operands see the pre-load value.
    applyStimulus(5'h01, 3'd1, 3'd1, 3'd6, 1'b1, 3'd1, 32'd100);
    completeOp(3'd6);
    checkDbg(3'd1);

    // Register 0 behaviour (ordinary or hard-wired zero depending on build).
    loadReg(3'd0, 32'h1234);
    applyStimulus(5'h01, 3'd1, 3'd2, 3'd0, 1'b0, 3'd0, 32'h0);
    completeOp(3'd0);
    checkOutput("pending_before_rst", 32'(exp_q.size()), 32'h0);

    // Reset during EXEC aborts the operation.
    req_valid = 1'b1; req_op = 5'h01; req_ra = 3'd1; req_rb = 3'd2; req_rd = 3'd5;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_exec_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 32'h0;
    #1;
    checkOutput("rst_abort_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_abort_done", 32'(done), 32'h0);
    for (int i = 0; i < 8; i++) checkDbg(3'(i));
    tick();
    tick();
    tick();

    // Normal operation resumes after the abort.
    loadReg(3'd1, 32'd7);
    applyStimulus(5'h01, 3'd1, 3'd1, 3'd2, 1'b0, 3'd0, 32'h0);
    completeOp(3'd2);
    tick();
    checkOutput("pending_at_end", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
